piso_shift_transmitter: RTL and testbench

- Parallel-in, serial-out transmitter. It is the sending end for the team's left-shift serial receiver.
- Accepts a SIZE-bit word through a valid/ready load handshake.
- Shifts the word out MSB-first, one bit per enabled clock. A receiver that shifts left on the same enable therefore reconstructs the word with its first bit at the MSB.
- Sits between a word-producing datapath and a serial link or a daisy-chained shift register.

---
 rtl/piso_shift_transmitter_pkg.sv | 22 ++
 rtl/piso_shift_transmitter_bit_counter.sv | 23 ++
 rtl/piso_shift_transmitter.sv | 115 +++++++++++
 tb/tb_piso_shift_transmitter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_shift_transmitter_pkg.sv
// Shared types and constants for the PISO shift transmitter.
// Build option: define PARITY_EN to append an even-parity bit to every frame.
package piso_shift_transmitter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Parity bit is XORed with this; 0 gives even parity.
  localparam logic PAR_ODD = 1'b0;

  // Index of the final bit of a frame, counted from 0.
  function automatic int frame_last(input int size);
`ifdef PARITY_EN
    return size;
`else
    return size - 1;
`endif
  endfunction

endpackage

// File: rtl/piso_shift_transmitter_bit_counter.sv
// Frame bit counter: synchronous clear has priority over increment;
// at_last flags that the count has reached the terminal value.
module piso_shift_transmitter_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         at_last
);

  always_ff @(posedge clk) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + W'(1);
  end

  assign at_last = (count == terminal);

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in, serial-out transmitter: valid/ready word load, MSB-first shift
// on each enable, one-cycle registered done pulse. Build option: PARITY_EN.
module piso_shift_transmitter
  import piso_shift_transmitter_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] data_in,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            enable,
  output logic            out,
  output logic            out_valid,
  output logic            done
);

  localparam int            CW     = $clog2(SIZE + 1);
  localparam int            LAST_I = frame_last(SIZE);
  localparam logic [CW-1:0] LAST   = CW'(LAST_I);

  state_t          state, state_nxt;
  logic [SIZE-1:0] shreg, shreg_nxt;
  logic            done_q, done_nxt;
  logic [CW-1:0]   cnt;
  logic            at_last;
  logic            cnt_clear, cnt_inc;
  logic            load_fire;
  logic            serial;
  logic            data_bit;

`ifdef PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (reset)          par <= 1'b0;
    else if (load_fire) par <= (^data_in) ^ PAR_ODD;
  end

  // Once all data bits are out the counter sits on SIZE and the parity bit goes out.
  assign data_bit = (cnt == CW'(SIZE)) ? par : shreg[SIZE-1];
`else
  assign data_bit = shreg[SIZE-1];
`endif

  piso_shift_transmitter_bit_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .terminal (LAST),
    .count    (cnt),
    .at_last  (at_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    done_nxt   = 1'b0;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    serial     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_nxt = data_in;
          cnt_clear = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        out_valid = 1'b1;
        serial    = data_bit;
        if (enable) begin
          if (at_last) begin
            // Final bit consumed: a waiting word follows with no idle gap.
            done_nxt   = 1'b1;
            load_ready = 1'b1;
            cnt_clear  = 1'b1;
            if (load_valid) begin
              shreg_nxt = data_in;
            end else begin
              shreg_nxt = '0;
              state_nxt = ST_IDLE;
            end
          end else begin
            shreg_nxt = shreg << 1;
            cnt_inc   = 1'b1;
          end
        end
      end
    endcase
  end

  assign load_fire = load_valid && load_ready;
  assign out       = serial;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Directed self-checking bench for piso_shift_transmitter (SIZE=8), covering
// both the default build and PARITY_EN.
module tb_piso_shift_transmitter;

`ifdef PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       enable;
  logic       out;
  logic       out_valid;
  logic       done;

  int checks = 0;
  int errors = 0;

  piso_shift_transmitter #(.SIZE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .enable     (enable),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected serial bit i of a frame carrying word w (bit 8 is even parity).
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    if (i < 8) return w[7-i];
    return ^w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b1; enable = 1'b1; data_in = 8'hFF;
    cyc(); cyc();
    load_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got out=%b ov=%b lr=%b done=%b want 0 0 1 0",
               out, out_valid, load_ready, done);
    end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // Load word w from IDLE; enable is asserted too and must be ignored.
  task automatic load_from_idle(input logic [7:0] w, input string name);
    data_in = w; load_valid = 1'b1; enable = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got lr=%b ov=%b want lr=1 ov=0", name, load_ready, out_valid);
    end
    cyc();
    load_valid = 1'b0; data_in = 8'h00;
  endtask

  task automatic test_basic();
    load_from_idle(8'hA5, "basic");
    enable = 1'b1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_bit(8'hA5, i) || out_valid !== 1'b1 || done !== 1'b0 ||
          load_ready !== (i == FL-1)) begin
        errors++;
        $display("FAIL basic_bit%0d got out=%b ov=%b done=%b lr=%b want out=%b ov=1 done=0 lr=%b",
                 i, out, out_valid, done, load_ready, exp_bit(8'hA5, i), (i == FL-1));
      end
      cyc();
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || load_ready !== 1'b1 || out !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b ov=%b lr=%b out=%b want 1 0 1 0",
               done, out_valid, load_ready, out);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width got done=%b want 0", done);
    end
    cyc();
  endtask

  // Receiver model shifts left on each enabled, valid bit.
  task automatic test_loopback();
    logic [7:0] rx = 8'h00;
    bit         seen = 0;
    load_from_idle(8'h3C, "loop");
    for (int k = 0; k < 3*FL; k++) begin
      enable = (k % 2 == 0);
      @(negedge clk);
      if (done === 1'b1 && !seen) begin
        seen = 1;
        checks++;
        if (rx !== 8'h3C) begin
          errors++;
          $display("FAIL loop_rx got %h want 3c", rx);
        end
      end
      if (enable && out_valid && rx_shift_ok(k)) rx = {rx[6:0], out};
      cyc();
    end
    enable = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL loop_done got no done pulse want one");
    end
  endtask

  // The parity bit is not part of the received word; stop after 8 data bits.
  function automatic bit rx_shift_ok(input int k);
    return (k / 2) < 8;
  endfunction

  task automatic test_back_to_back();
    load_from_idle(8'hFF, "b2b");
    enable = 1'b1;
    for (int i = 0; i < 2*FL; i++) begin
      load_valid = (i < FL);
      data_in    = 8'h00;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 ||
          out !== ((i < FL) ? exp_bit(8'hFF, i) : exp_bit(8'h00, i-FL)) ||
          done !== (i == FL) || load_ready !== (i == FL-1 || i == 2*FL-1)) begin
        errors++;
        $display("FAIL b2b_cyc%0d got ov=%b out=%b done=%b lr=%b", i, out_valid, out, done, load_ready);
      end
      cyc();
    end
    load_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got done=%b ov=%b want 1 0", done, out_valid);
    end
    cyc();
  endtask

  task automatic test_enable_gaps();
    int nb = 0;
    load_from_idle(8'h81, "gap");
    for (int k = 0; nb < FL && k < 100; k++) begin
      enable = (k % 3 == 0);
      @(negedge clk);
      checks++;
      if (out !== exp_bit(8'h81, nb) || out_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL gap_k%0d got out=%b ov=%b done=%b want out=%b ov=1 done=0",
                 k, out, out_valid, done, exp_bit(8'h81, nb));
      end
      if (enable) nb++;
      cyc();
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_done got done=%b ov=%b want 1 0", done, out_valid);
    end
    cyc();
  endtask

  task automatic test_reset_midframe();
    int pulses = 0;
    load_from_idle(8'hF0, "rstmid");
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_bit%0d got out=%b want 1", i, out);
      end
      cyc();
    end
    reset = 1'b1; load_valid = 1'b0;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0 || out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after got ov=%b lr=%b done=%b out=%b want 0 1 0 0",
               out_valid, load_ready, done, out);
    end
    for (int i = 0; i < 12; i++) begin
      cyc();
      @(negedge clk);
      if (done !== 1'b0) pulses++;
    end
    cyc();
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rstmid_nodone got %0d done cycles want 0", pulses);
    end
    enable = 1'b0;
    load_from_idle(8'h0F, "rstnew");
    enable = 1'b1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_bit(8'h0F, i) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rstnew_bit%0d got out=%b ov=%b want out=%b ov=1",
                 i, out, out_valid, exp_bit(8'h0F, i));
      end
      cyc();
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rstnew_done got done=%b want 1", done);
    end
    cyc();
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [8:0] got;
    logic [7:0] words [2] = '{8'h07, 8'h03};
    logic [8:0] want  [2] = '{9'b000001111, 9'b000000110};
    for (int w = 0; w < 2; w++) begin
      got = '0;
      load_from_idle(words[w], "par");
      enable = 1'b1;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        got = {got[7:0], out};
        cyc();
      end
      enable = 1'b0;
      checks++;
      if (got !== want[w]) begin
        errors++;
        $display("FAIL par_word%0d got %b want %b", w, got, want[w]);
      end
      cyc();
    end
  endtask
`endif

  initial begin
    reset = 1'b1; data_in = 8'h00; load_valid = 1'b0; enable = 1'b0;
    test_reset();
    test_basic();
    test_loopback();
    test_back_to_back();
    test_enable_gaps();
    test_reset_midframe();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
